// File: rtl/ws2812_serializer.sv
// WS2812 single-wire line driver: pulls colour bytes from upstream and serialises them
// MSB-first with fixed high/low pulse widths, then holds the line low for the latch interval.
module ws2812_serializer #(
  parameter int T0H_CYCLES   = 4,
  parameter int T1H_CYCLES   = 8,
  parameter int BIT_CYCLES   = 15,
  parameter int LATCH_CYCLES = 3600,
  parameter int NUM_BYTES    = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       byte_req,
  output logic       busy,
  output logic       done,
  output logic       dout
);

  localparam int CNT_MAX = (BIT_CYCLES > LATCH_CYCLES) ? BIT_CYCLES : LATCH_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int BW      = $clog2(NUM_BYTES) + 1;

  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] T0H_W      = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] T1H_W      = CW'(T1H_CYCLES);
  localparam logic [BW-1:0] NB_W       = BW'(NUM_BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BIT   = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [7:0]    sh_q, sh_d;
  logic          req_d, done_d, busy_d, dout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      sh_q     <= '0;
      byte_req <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dout     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      sh_q     <= sh_d;
      byte_req <= req_d;
      busy     <= busy_d;
      done     <= done_d;
      dout     <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sh_d    = sh_q;
    req_d   = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_d    = byte_in;
          bit_d   = 3'd0;
          cyc_d   = '0;
          byte_d  = BW'(1);
          req_d   = 1'b1;
          state_d = S_BIT;
        end
      end

      S_BIT: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d = '0;
          if (bit_q != 3'd7) begin
            sh_d  = {sh_q[6:0], 1'b0};
            bit_d = bit_q + 3'd1;
          end else if (byte_q < NB_W) begin
            // Back-to-back byte: the next byte's first bit follows with no gap
            sh_d   = byte_in;
            bit_d  = 3'd0;
            byte_d = byte_q + BW'(1);
            req_d  = 1'b1;
          end else begin
            state_d = S_LATCH;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      S_LATCH: begin
        if (cyc_q == LATCH_LAST) begin
          cyc_d   = '0;
          byte_d  = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
        bit_d   = '0;
        byte_d  = '0;
      end
    endcase

    // Outputs are derived from the next state so they can be registered with no extra lag
    busy_d = (state_d != S_IDLE);
    dout_d = (state_d == S_BIT) && (cyc_d < (sh_d[7] ? T1H_W : T0H_W));
  end

endmodule

// File: tb/tb_ws2812_serializer.sv
// Bench for ws2812_serializer: random and directed frames checked cycle by cycle against
// an expected-output queue built from the pulse-width rules with plain arithmetic.
module tb_ws2812_serializer;

  localparam int T0H   = 2;
  localparam int T1H   = 4;
  localparam int BITC  = 6;
  localparam int LATCH = 10;
  localparam int NB    = 2;
  localparam int F     = 8 * NB * BITC;
  localparam int FL    = F + LATCH + 1;
  localparam int TAIL  = 5;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] byte_in;
  logic       byte_req;
  logic       busy;
  logic       done;
  logic       dout;

  int errors = 0;
  int checks = 0;

  // {byte_req, busy, done, dout} per cycle
  logic [3:0] exp_q[$];
  logic [7:0] fb[0:3][0:NB-1];

  ws2812_serializer #(
    .T0H_CYCLES  (T0H),
    .T1H_CYCLES  (T1H),
    .BIT_CYCLES  (BITC),
    .LATCH_CYCLES(LATCH),
    .NUM_BYTES   (NB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .byte_in (byte_in),
    .byte_req(byte_req),
    .busy    (busy),
    .done    (done),
    .dout    (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int cyc, input logic [3:0] obs,
                       input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s cycle=%0d observed(req,busy,done,dout)=%b expected=%b",
             tag, cyc, obs, exp);
    end
  endtask

  // Expected outputs for frame k at cycle c (c=1 is the cycle after the start edge)
  function automatic logic [3:0] frame_exp(input int k, input int c);
    int   idx, n, i, ph;
    logic bv, req, hi;
    if (c <= F) begin
      idx = c - 1;
      n   = idx / (8 * BITC);
      i   = (idx / BITC) % 8;
      ph  = idx % BITC;
      bv  = fb[k][n][7-i];
      req = ((idx % (8 * BITC)) == 0);
      hi  = (ph < (bv ? T1H : T0H));
      return {req, 1'b1, 1'b0, hi};
    end else if (c <= F + LATCH) begin
      return 4'b0100;
    end
    return 4'b0010;
  endfunction

  // Returns the byte that must be on byte_in during cycle g, or -1 if g is not a load cycle
  function automatic int load_byte(input int g, input int nf);
    for (int k = 0; k < nf; k++)
      for (int n = 0; n < NB; n++)
        if (g == k * FL + n * 8 * BITC) return int'(fb[k][n]);
    return -1;
  endfunction

  // Runs nf frames (chained through a held start when hold=1). abort_at>0 resets mid-frame.
  task automatic run_frames(input string tag, input int nf, input bit scramble,
                            input bit hold, input bit poke, input int abort_at);
    int         total, lb, k, c;
    logic [3:0] obs, exp;
    exp_q.delete();
    total = nf * FL;
    for (int g = 1; g <= total; g++) begin
      k = (g - 1) / FL;
      c = g - k * FL;
      exp_q.push_back(frame_exp(k, c));
    end
    for (int g = 0; g < TAIL; g++) exp_q.push_back(4'b0000);

    @(negedge clk);
    start   = 1'b1;
    byte_in = fb[0][0];

    for (int g = 1; g <= total + TAIL; g++) begin
      @(negedge clk);
      obs = {byte_req, busy, done, dout};
      exp = exp_q.pop_front();
      check(tag, g, obs, exp);

      if (g == abort_at) begin
        rst_n = 1'b0;
        #1;
        check({tag, "_async_rst"}, g, {byte_req, busy, done, dout}, 4'b0000);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_rst_hold"}, g, {byte_req, busy, done, dout}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < TAIL; j++) begin
          @(negedge clk);
          check({tag, "_post_rst"}, j, {byte_req, busy, done, dout}, 4'b0000);
        end
        exp_q.delete();
        return;
      end

      if (hold) start = (g <= (nf - 1) * FL);
      else      start = poke && (g == 5 || g == 60 || g == 100);

      lb = load_byte(g, nf);
      if (lb >= 0)       byte_in = 8'(lb);
      else if (scramble) byte_in = 8'($urandom_range(0, 255));
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    byte_in = 8'h00;

    // Reset state, then a quiet line with start low after release
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", 0, {byte_req, busy, done, dout}, 4'b0000);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_after_reset", i, {byte_req, busy, done, dout}, 4'b0000);
    end

    fb[0][0] = 8'hA5; fb[0][1] = 8'h3C;
    run_frames("frame_a5_3c", 1, 1'b1, 1'b0, 1'b0, 0);

    fb[0][0] = 8'h00; fb[0][1] = 8'hFF;
    run_frames("frame_00_ff", 1, 1'b1, 1'b0, 1'b0, 0);

    fb[0][0] = 8'h5A; fb[0][1] = 8'hC3;
    run_frames("start_while_busy", 1, 1'b1, 1'b0, 1'b1, 0);

    fb[0][0] = 8'h81; fb[0][1] = 8'h7E;
    fb[1][0] = 8'($urandom_range(0, 255)); fb[1][1] = 8'($urandom_range(0, 255));
    run_frames("start_held", 2, 1'b1, 1'b1, 1'b0, 0);

    fb[0][0] = 8'hF0; fb[0][1] = 8'h0F;
    run_frames("abort_mid_frame", 1, 1'b1, 1'b0, 1'b0, 30);
    fb[0][0] = 8'h96; fb[0][1] = 8'h69;
    run_frames("after_abort", 1, 1'b1, 1'b0, 1'b0, 0);

    for (int r = 0; r < 4; r++) begin
      fb[0][0] = 8'($urandom_range(0, 255));
      fb[0][1] = 8'($urandom_range(0, 255));
      run_frames("random_frame", 1, 1'b1, 1'b0, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
